// File: rtl/load_arb_pkg.sv
// load_arb shared types and constants.
// Default sizes, source-index type and statistics counter type.
package load_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;

    typedef logic [$clog2(NREQ_DEF)-1:0] src_t;

    typedef logic [15:0] cnt_t;
    localparam cnt_t CNT_SAT = 16'hFFFF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches from ptr upward, wrapping, first set request wins.
module rr_pick
    import load_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int SW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [SW-1:0]   idx,
    output logic            any
);

    int          j;
    logic [SW-1:0] sel;

    // Walk the rotated request vector and stop at the first hit.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            j   = (int'(ptr) + k) % NREQ;
            sel = SW'(j);
            if (!any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
    end

endmodule

// File: rtl/load_arb.sv
// Round-robin N:1 arbiter with a single-entry output register.
// Optional per-requester grant counters: LOAD_ARB_STATS_EN.
module load_arb
    import load_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(NREQ)-1:0] out_src,
    input  logic                    out_ready
`ifdef LOAD_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]      grant_cnt
`endif
);

    localparam int SW = $clog2(NREQ);

    logic [SW-1:0]   ptr;
    logic [NREQ-1:0] gnt;
    logic [SW-1:0]   g_idx;
    logic            g_any;
    logic            accept;
    logic            xfer;

    rr_pick #(.NREQ(NREQ), .SW(SW)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (g_idx),
        .any (g_any)
    );

    // Accept when the register is empty or draining this cycle.
    always_comb begin
        accept    = (!out_valid || out_ready) && !rst;
        req_ready = gnt & {NREQ{accept}};
        xfer      = g_any && accept;
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= req_data[int'(g_idx)*DW +: DW];
            out_src   <= g_idx;
            ptr       <= (g_idx == SW'(NREQ-1)) ? '0 : g_idx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LOAD_ARB_STATS_EN
    cnt_t cnt [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        // Saturating count of transfers from requester i.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt[i] <= '0;
            end else if (req_ready[i] && req_valid[i] && cnt[i] != CNT_SAT) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
        assign grant_cnt[i*16 +: 16] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_load_arb.sv
// Testbench for load_arb: reference model plus directed and random stimulus.
// Statistics checks compile only with LOAD_ARB_STATS_EN.
module tb_load_arb;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_src;
    logic              out_ready = 1'b0;
`ifdef LOAD_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state.
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_ptr;
    int            m_cnt [NREQ];

    load_arb #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
`ifdef LOAD_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid index at or after p, wrapping; -1 if none.
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g;
        logic [NREQ-1:0] r;
        r = '0;
        g = pick(req_valid, m_ptr);
        if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Reference model: advances on each rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= 0;
            m_ptr   <= 0;
            for (int i = 0; i < NREQ; i++) m_cnt[i] <= 0;
        end else begin
            int g;
            g = pick(req_valid, m_ptr);
            if ((!m_valid || out_ready) && g >= 0) begin
                m_valid  <= 1'b1;
                m_data   <= req_data[g*DW +: DW];
                m_src    <= g;
                m_ptr    <= (g + 1) % NREQ;
                m_cnt[g] <= (m_cnt[g] >= 65535) ? 65535 : m_cnt[g] + 1;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare DUT against the model every cycle, mid-period.
    always @(negedge clk) begin
        chk("req_ready", req_ready, exp_ready());
        chk("onehot", $countones(req_ready) <= 1, 1);
        chk("out_valid", out_valid, m_valid);
        if (m_valid || rst) begin
            chk("out_data", out_data, m_data);
            chk("out_src", out_src, m_src);
        end
`ifdef LOAD_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            chk("grant_cnt", grant_cnt[i*16 +: 16], m_cnt[i]);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        req_valid = '0;
        tick();
        #2 rst = 1'b0;
        tick();
    endtask

    int seq [8];
    logic [DW-1:0] hold_d;
    logic [1:0]    hold_s;

    initial begin
        do_reset();
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);

        // Single requester.
        tick();
        req_valid = 4'b0100;
        req_data  = 32'h005A_0000;
        out_ready = 1'b1;
        @(negedge clk);
        chk("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'h5A);
        chk("single_src", out_src, 2);

        // Fairness from a fresh pointer.
        do_reset();
        req_valid = 4'b1111;
        req_data  = 32'h4433_2211;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            seq[i] = out_src;
        end
        for (int i = 0; i < 8; i++)
            chk("rr_seq", seq[i], i % 4);

        // Backpressure.
        out_ready = 1'b0;
        tick();
        @(negedge clk);
        hold_d = out_data;
        hold_s = out_src;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("bp_ready", req_ready, 0);
            chk("bp_data", out_data, hold_d);
            chk("bp_src", out_src, hold_s);
        end
        #1 out_ready = 1'b1;
        #1 chk("bp_release", req_ready != 0, 1);

        // Pointer wrap: set ptr to 3 via a grant on 2.
        do_reset();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b1001;
        @(negedge clk);
        chk("wrap_g3", req_ready, 4'b1000);
        tick();
        @(negedge clk);
        chk("wrap_g0", req_ready, 4'b0001);

        // Reset between edges while holding a payload.
        tick();
        out_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1 chk("rst_async_valid", out_valid, 0);
        chk("rst_ready", req_ready, 0);
        tick();
        #2 rst = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1 chk("post_rst_g0", req_ready, 4'b0001);

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            tick();
            req_valid = NREQ'($urandom);
            req_data  = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
        end

`ifdef LOAD_ARB_STATS_EN
        do_reset();
        req_valid = 4'b0010;
        out_ready = 1'b1;
        for (int c = 0; c < 70000; c++) tick();
        @(negedge clk);
        chk("sat_cnt1", grant_cnt[31:16], 16'hFFFF);
        chk("sat_cnt0", grant_cnt[15:0], 0);
        chk("sat_cnt3", grant_cnt[63:48], 0);
        do_reset();
        @(negedge clk);
        chk("cnt_cleared", grant_cnt, 0);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
